// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage GCD CPU.
// Opcodes, the bubble encoding and the fetch FSM states.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_ADD = 6'd32;

  // add $0,$0,$0 : ID writes nothing, unlike all-zero
  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_shadow_ctrl.sv
// RUN/SHADOW control for the IF stage.
// Counts bubble cycles after a fetched beq.
module if_shadow_ctrl
  import cpu_pkg::*;
#(
  parameter int SHADOW_NOPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       br_taken,
  input  logic [5:0] op,
  output if_state_t  state,
  output logic       bubble
);

  if_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // next state: enter SHADOW on beq, leave on redirect or expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (!stall && op == OP_BEQ) begin
          state_d = SHADOW;
          cnt_d   = 3'(SHADOW_NOPS);
        end
      end
      SHADOW: begin
        if (br_taken) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else if (!stall) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state  = state_q;
  assign bubble = (state_q == SHADOW);

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, resolves j locally and
// bubbles behind beq until EX reports the outcome.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int          IMEM_AW     = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          SHADOW_NOPS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        IR,
  output logic [31:0]        PC,
  output logic               if_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pco_q, pco_d;
  logic        vld_q, vld_d;
  logic        just_rst_q;

  logic [31:0] pc_plus4;
  logic [31:0] j_target;
  logic [31:0] br_aligned;
  logic [5:0]  op;
  if_state_t   state;
  logic        bubble;

  assign pc_plus4   = pc_q + 32'd4;
  assign op         = imem_rdata[31:26];
  assign j_target   = {pc_plus4[31:28],
                       imem_rdata[25:0], 2'b00};
  assign br_aligned = br_target & ~32'h3;
  assign imem_addr  = pc_q[IMEM_AW+1:2];

  if_shadow_ctrl #(
    .SHADOW_NOPS(SHADOW_NOPS)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .br_taken(br_taken),
    .op      (op),
    .state   (state),
    .bubble  (bubble)
  );

  // next-PC mux and IF/ID register inputs
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    pco_d = pco_q;
    vld_d = vld_q;
    if (bubble) begin
      ir_d  = NOP_INSTR;
      vld_d = 1'b0;
      if (br_taken) begin
        pc_d = br_aligned;
      end
    end else if (!stall) begin
      ir_d  = imem_rdata;
      pco_d = pc_plus4;
      vld_d = 1'b1;
      pc_d  = (op == OP_J) ? j_target : pc_plus4;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      pco_q      <= 32'd0;
      vld_q      <= 1'b0;
      just_rst_q <= 1'b1;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      pco_q      <= pco_d;
      vld_q      <= vld_d;
      just_rst_q <= 1'b0;
    end
  end

  assign IR       = ir_q;
  assign PC       = pco_q;
  assign if_valid = vld_q;

  // br_taken outside SHADOW is a protocol error, except
  // the stale pulse of a beq discarded by a reset
  a_no_br_in_run : assert property (
    @(posedge clk)
    !(rst && !just_rst_q && state == RUN && br_taken)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch.
// Expected IF/ID values are queued per cycle, then popped.
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0020;
  localparam logic [31:0] JMP  = 32'h0800_0010;
  localparam logic [31:0] BEQ  = 32'h1022_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic [31:0] PC;
  logic        if_valid;

  logic [31:0] rom [256];

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  instruction_fetch #(
    .IMEM_AW    (8),
    .RESET_PC   (32'h0000_0000),
    .SHADOW_NOPS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .IR        (IR),
    .PC        (PC),
    .if_valid  (if_valid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic expect_out(input logic [31:0] ir,
                            input logic [31:0] pc,
                            input logic        v);
    exp_t e;
    e.ir = ir;
    e.pc = pc;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic step(input string tag,
                      input logic r,
                      input logic s,
                      input logic b,
                      input logic [31:0] t);
    exp_t e;
    rst       = r;
    stall     = s;
    br_taken  = b;
    br_target = t;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".IR"}, IR, e.ir);
      chk({tag, ".PC"}, PC, e.pc);
      chk({tag, ".vld"}, {31'd0, if_valid},
          {31'd0, e.v});
    end
  endtask

  function automatic logic [31:0] add_i(input int i);
    return 32'h0000_0020 | (32'(i) << 11);
  endfunction

  task automatic init_rom();
    for (int i = 0; i < 256; i++) rom[i] = add_i(i);
  endtask

  task automatic do_reset(input string tag);
    expect_out(NOP, 32'd0, 1'b0);
    expect_out(NOP, 32'd0, 1'b0);
    step({tag, ".rst0"}, 1'b0, 1'b0, 1'b0, 32'd0);
    step({tag, ".rst1"}, 1'b0, 1'b1, 1'b0, 32'd0);
    chk({tag, ".addr"}, {24'd0, imem_addr}, 32'd0);
  endtask

  task automatic run_to_beq(input string tag);
    expect_out(rom[0], 32'd4, 1'b1);
    expect_out(rom[1], 32'd8, 1'b1);
    expect_out(BEQ, 32'd12, 1'b1);
    step({tag, ".f0"}, 1'b1, 1'b0, 1'b0, 32'd0);
    step({tag, ".f1"}, 1'b1, 1'b0, 1'b0, 32'd0);
    step({tag, ".f2"}, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'd0;
    init_rom();

    // reset and sequential fetch with a RUN stall
    do_reset("rst");
    expect_out(rom[0], 32'd4, 1'b1);
    expect_out(rom[1], 32'd8, 1'b1);
    expect_out(rom[1], 32'd8, 1'b1);
    expect_out(rom[2], 32'd12, 1'b1);
    expect_out(rom[3], 32'd16, 1'b1);
    step("seq0", 1'b1, 1'b0, 1'b0, 32'd0);
    step("seq1", 1'b1, 1'b0, 1'b0, 32'd0);
    step("seq_stall", 1'b1, 1'b1, 1'b0, 32'd0);
    step("seq2", 1'b1, 1'b0, 1'b0, 32'd0);
    step("seq3", 1'b1, 1'b0, 1'b0, 32'd0);

    // jump with no bubble
    init_rom();
    rom[1] = JMP;
    do_reset("jrst");
    expect_out(rom[0], 32'd4, 1'b1);
    expect_out(JMP, 32'd8, 1'b1);
    expect_out(rom[16], 32'd68, 1'b1);
    expect_out(rom[17], 32'd72, 1'b1);
    step("j0", 1'b1, 1'b0, 1'b0, 32'd0);
    step("j1", 1'b1, 1'b0, 1'b0, 32'd0);
    step("j16", 1'b1, 1'b0, 1'b0, 32'd0);
    step("j17", 1'b1, 1'b0, 1'b0, 32'd0);

    // branch taken in second shadow cycle
    init_rom();
    rom[2] = BEQ;
    do_reset("btrst");
    run_to_beq("bt");
    expect_out(NOP, 32'd12, 1'b0);
    expect_out(NOP, 32'd12, 1'b0);
    expect_out(rom[16], 32'd68, 1'b1);
    expect_out(rom[17], 32'd72, 1'b1);
    step("bt_sh1", 1'b1, 1'b0, 1'b0, 32'd0);
    step("bt_sh2", 1'b1, 1'b0, 1'b1, 32'h40);
    step("bt_tgt", 1'b1, 1'b0, 1'b0, 32'd0);
    step("bt_nxt", 1'b1, 1'b0, 1'b0, 32'd0);

    // not taken, one stalled shadow cycle
    do_reset("ntrst");
    run_to_beq("nt");
    expect_out(NOP, 32'd12, 1'b0);
    expect_out(NOP, 32'd12, 1'b0);
    expect_out(NOP, 32'd12, 1'b0);
    expect_out(rom[3], 32'd16, 1'b1);
    step("nt_sh1", 1'b1, 1'b1, 1'b0, 32'd0);
    step("nt_sh2", 1'b1, 1'b0, 1'b0, 32'd0);
    step("nt_sh3", 1'b1, 1'b0, 1'b0, 32'd0);
    step("nt_ft", 1'b1, 1'b0, 1'b0, 32'd0);

    // br_taken beats stall, low target bits forced to 0
    do_reset("bsrst");
    run_to_beq("bs");
    expect_out(NOP, 32'd12, 1'b0);
    expect_out(rom[32], 32'h84, 1'b1);
    step("bs_sh1", 1'b1, 1'b1, 1'b1, 32'h83);
    step("bs_tgt", 1'b1, 1'b0, 1'b0, 32'd0);

    // redirect to top of address space, PC wraps
    do_reset("wrst");
    run_to_beq("w");
    expect_out(NOP, 32'd12, 1'b0);
    expect_out(rom[255], 32'd0, 1'b1);
    expect_out(rom[0], 32'd4, 1'b1);
    step("w_sh1", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("w_top", 1'b1, 1'b0, 1'b0, 32'd0);
    step("w_wrap", 1'b1, 1'b0, 1'b0, 32'd0);

    // reset mid-shadow drops the pending branch
    do_reset("mrst");
    run_to_beq("m");
    expect_out(NOP, 32'd0, 1'b0);
    expect_out(rom[0], 32'd4, 1'b1);
    expect_out(rom[1], 32'd8, 1'b1);
    step("m_rst", 1'b0, 1'b0, 1'b0, 32'd0);
    chk("m_addr", {24'd0, imem_addr}, 32'd0);
    step("m_f0", 1'b1, 1'b0, 1'b1, 32'h40);
    step("m_f1", 1'b1, 1'b0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
